// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Turns a valid/ready command stream into APB3 transfers. Only one transfer
//   is outstanding at a time. Each command returns exactly one response on a
//   valid/ready response channel. The bridge is the requester on the APB bus
//   and drives the slave directly.
//
// Optional feature (macro APB_TIMEOUT_EN):
//   When APB_TIMEOUT_EN is defined, a wait-state counter aborts an ACCESS
//   phase that has waited TIMEOUT_CYCLES cycles and still sees pready low.
//   The aborted transfer returns rsp_err = 1 and rsp_rdata = 0.
//   When APB_TIMEOUT_EN is undefined, ACCESS waits for pready indefinitely.
//
// Parameters:
//   ADDR_W          width of cmd_addr / paddr
//   DATA_W          width of cmd_wdata / pwdata / prdata / rsp_rdata
//   TIMEOUT_CYCLES  wait-state limit before an abort (timeout build, >= 1)
//
// Ports:
//   pclk, prst                    clock and synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (cmd_ready combinational)
//   cmd_write/cmd_addr/cmd_wdata  command payload, sampled on acceptance
//   rsp_valid / rsp_ready         response handshake
//   rsp_rdata / rsp_err           response payload (rdata is 0 for writes)
//   psel/penable/pwrite/paddr/pwdata   APB requester outputs (registered)
//   prdata/pready/pslverr              APB slave returns
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // A zero or negative limit would make the abort fire on the very first
  // ACCESS cycle, so it is rejected when the design is elaborated.
  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  state_t            r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_rspErr;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_MAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] r_waitCount;
`endif

  // The bridge accepts commands only while IDLE. The !prst term stops a
  // command from being handshaked in the same cycle that reset wipes it.
  assign cmd_ready = (r_state == IDLE) && !prst;

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

  // Single-process FSM. The bus and response outputs are registered here.
  // paddr, pwrite and pwdata keep the last command outside a transfer.
  // Only reset clears them.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state    <= IDLE;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_waitCount <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end

        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          r_waitCount <= '0;
`endif
        end

        ACCESS: begin
          if (pready) begin
            // A write always returns zero read data. This holds even if
            // the slave drives prdata during the write.
            r_rspRdata <= r_pwrite ? '0 : prdata;
            r_rspErr   <= pslverr;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_waitCount == TIMEOUT_MAX) begin
            // The slave never answered. Drop the bus and report the error.
            r_rspRdata <= '0;
            r_rspErr   <= 1'b1;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_waitCount <= r_waitCount + CW'(1);
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge. The bench plays the APB slave by
// driving pready/prdata/pslverr directly. It also drives the command and
// response channels. Inputs change on the falling edge, and outputs are
// sampled on the falling edge, away from the rising edge where the DUT
// updates.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TOUT   = 4;

  logic              pclk = 1'b0;
  logic              prst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int compareCount  = 0;
  int mismatchCount = 0;

  apb_master_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  // Free-running clock with a 10-unit period.
  always #5 pclk = ~pclk;

  // Stops a runaway simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    cmd_valid = valid;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  initial begin
    prst      = 1'b1;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    // ---------------- Reset state ----------------
    tick();
    tick();
    checkOutput("rst_psel",      psel,      0);
    checkOutput("rst_penable",   penable,   0);
    checkOutput("rst_rspValid",  rsp_valid, 0);
    checkOutput("rst_paddr",     paddr,     0);
    checkOutput("rst_rdata",     rsp_rdata, 0);
    checkOutput("rst_cmdReady",  cmd_ready, 0);
    prst = 1'b0;
    #1;
    checkOutput("idle_cmdReady", cmd_ready, 1);

    // ---------------- Write, zero wait ----------------
    applyStimulus(1'b1, 1'b1, 8'h12, 8'hA5);
    pready = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("wr_setup_psel",    psel,      1);
    checkOutput("wr_setup_penable", penable,   0);
    checkOutput("wr_setup_paddr",   paddr,     8'h12);
    checkOutput("wr_setup_pwdata",  pwdata,    8'hA5);
    checkOutput("wr_setup_pwrite",  pwrite,    1);
    checkOutput("wr_setup_cmdRdy",  cmd_ready, 0);
    tick();
    checkOutput("wr_access_psel",    psel,    1);
    checkOutput("wr_access_penable", penable, 1);
    tick();
    checkOutput("wr_rsp_valid",   rsp_valid, 1);
    checkOutput("wr_rsp_err",     rsp_err,   0);
    checkOutput("wr_rsp_rdata",   rsp_rdata, 8'h00);
    checkOutput("wr_rsp_psel",    psel,      0);
    checkOutput("wr_rsp_penable", penable,   0);
    checkOutput("wr_keep_paddr",  paddr,     8'h12);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("wr_done_rspValid", rsp_valid, 0);
    checkOutput("wr_done_cmdReady", cmd_ready, 1);

    // ---------------- Read, 3 wait states ----------------
    applyStimulus(1'b1, 1'b0, 8'h40, 8'h99);
    pready = 1'b0;
    prdata = 8'h77;
    tick();
    applyStimulus(1'b0, 1'b1, 8'hEE, 8'hEE);
    checkOutput("rd_setup_psel",  psel,   1);
    checkOutput("rd_setup_pwdata", pwdata, 8'h99);
    tick();
    checkOutput("rd_access_penable", penable, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rd_wait_psel",    psel,      1);
      checkOutput("rd_wait_penable", penable,   1);
      checkOutput("rd_wait_paddr",   paddr,     8'h40);
      checkOutput("rd_wait_pwrite",  pwrite,    0);
      checkOutput("rd_wait_rspV",    rsp_valid, 0);
    end
    pready = 1'b1;
    prdata = 8'h3C;
    tick();
    prdata = 8'h00;
    checkOutput("rd_rsp_valid", rsp_valid, 1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 8'h3C);
    checkOutput("rd_rsp_err",   rsp_err,   0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rd_done_rspValid", rsp_valid, 0);

    // ---------------- Slave error then backpressure ----------------
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'h11);
    pready  = 1'b1;
    pslverr = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    pslverr = 1'b0;
    checkOutput("err_rsp_valid", rsp_valid, 1);
    checkOutput("err_rsp_err",   rsp_err,   1);
    checkOutput("err_rsp_rdata", rsp_rdata, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h22, 8'h00);
    prdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_cmdReady", cmd_ready, 0);
      checkOutput("bp_rspValid", rsp_valid, 1);
      checkOutput("bp_rspErr",   rsp_err,   1);
      checkOutput("bp_psel",     psel,      0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_release_rspV", rsp_valid, 0);
    checkOutput("bp_release_cRdy", cmd_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("bp_second_psel",  psel,   1);
    checkOutput("bp_second_paddr", paddr,  8'h22);
    checkOutput("bp_second_pwr",   pwrite, 0);
    tick();
    tick();
    checkOutput("bp_second_rdata", rsp_rdata, 8'h5A);
    checkOutput("bp_second_err",   rsp_err,   0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    prdata = 8'h00;

    // ---------------- Reset mid-ACCESS ----------------
    applyStimulus(1'b1, 1'b0, 8'h33, 8'h00);
    pready = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("mr_wait_penable", penable, 1);
    prst = 1'b1;
    tick();
    prst = 1'b0;
    checkOutput("mr_psel",     psel,      0);
    checkOutput("mr_penable",  penable,   0);
    checkOutput("mr_rspValid", rsp_valid, 0);
    pready = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h0F);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("mr_post_paddr", paddr, 8'h01);
    tick();
    tick();
    checkOutput("mr_post_rspV",  rsp_valid, 1);
    checkOutput("mr_post_err",   rsp_err,   0);
    checkOutput("mr_post_rdata", rsp_rdata, 8'h00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // ---------------- Timeout abort ----------------
    applyStimulus(1'b1, 1'b0, 8'h44, 8'h00);
    pready = 1'b0;
    prdata = 8'hC3;
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    for (int i = 0; i < TOUT; i++) begin
      tick();
      checkOutput("to_wait_psel", psel,      1);
      checkOutput("to_wait_rspV", rsp_valid, 0);
    end
    tick();
    checkOutput("to_abort_rspV",  rsp_valid, 1);
    checkOutput("to_abort_err",   rsp_err,   1);
    checkOutput("to_abort_rdata", rsp_rdata, 8'h00);
    checkOutput("to_abort_psel",  psel,      0);
    checkOutput("to_abort_pen",   penable,   0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream into APB3 transfers on the shared `apb_if` signal set (psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr).
- Returns one response per command on a valid/ready response channel.
- Sits directly upstream of the APB slave as the bus requester.
- Issues one outstanding transfer at a time and must satisfy every bus-protocol assertion on the interface.

Parameters:
- ADDR_W, 8, width of cmd_addr and paddr
- DATA_W, 8, width of wdata, prdata and rsp_rdata
- TIMEOUT_CYCLES, 16, maximum wait-state cycles in ACCESS before abort (used only with APB_TIMEOUT_EN; must be >= 1)

Ports:
- pclk  in  1  clock; all logic on rising edge
- prst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  pslverr captured, or timeout abort
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset is synchronous: prst high at a rising edge forces state IDLE. All registered outputs go to 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err.
- Reset mid-transfer drops psel/penable on the next edge with no response. Any held response is discarded.
- All bus and response outputs are registered. cmd_ready is combinational: (state == IDLE) && !prst.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, set psel = 1, go to SETUP.
  - SETUP: psel = 1, penable = 0. Unconditionally set penable = 1 and go to ACCESS.
  - ACCESS: psel = 1, penable = 1.
    - If pready = 1: capture rsp_rdata = (pwrite ? 0 : prdata) and rsp_err = pslverr, clear psel/penable, set rsp_valid = 1, go to RESP.
    - If pready = 0: hold all bus outputs stable.
  - RESP: rsp_valid = 1 and rsp_rdata/rsp_err held until rsp_ready = 1, then clear rsp_valid and go to IDLE.
- Latency: command accepted at edge N puts SETUP at N+1 and ACCESS at N+2. With zero wait states, rsp_valid is visible after N+3. The minimum command-to-command period is 4 cycles with rsp_ready held high.
- paddr, pwrite and pwdata keep their last value outside transfers; they are not re-zeroed. pwdata is driven with the latched value on reads too.
- pslverr and prdata are sampled only in ACCESS with pready = 1 and ignored at all other times.
- cmd_* inputs are ignored outside IDLE. The command is captured only on the cmd_valid && cmd_ready edge.
- penable never asserts without psel. penable always drops the cycle after completion.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments on each ACCESS cycle with pready = 0.
  - When the count equals TIMEOUT_CYCLES and pready is still 0, the transfer aborts: psel/penable cleared, rsp_rdata = 0, rsp_err = 1, go to RESP.
  - The abort intentionally violates the stable-while-waiting bus check. The bench expects that single firing and disables the zero-wait check for the test.
- When undefined: no counter is built, and ACCESS waits indefinitely for pready.

Test Plan:
- Write, zero-wait: cmd write addr 0x12 data 0xA5, pready = 1 -> SETUP at cycle 1 (psel = 1, penable = 0, paddr = 0x12, pwdata = 0xA5, pwrite = 1), ACCESS at cycle 2, then rsp_valid = 1, rsp_err = 0, rsp_rdata = 0x00.
- Read with 3 wait states: cmd read addr 0x40, pready low for 3 ACCESS cycles then high with prdata = 0x3C -> bus signals stable throughout, then rsp_rdata = 0x3C, rsp_err = 0.
- Slave error: write addr 0xFF, pslverr = 1 together with pready = 1 -> rsp_err = 1. The next command is accepted only after rsp_ready.
- Response backpressure: rsp_ready held low 5 cycles with a second cmd_valid pending -> cmd_ready = 0, rsp values held; rsp_ready = 1 -> IDLE, second command accepted the following cycle.
- Reset mid-ACCESS: assert prst during a wait state -> psel = penable = rsp_valid = 0 next edge; post-reset write to 0x01 completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 4: pready held 0 -> abort after 4 wait cycles, rsp_err = 1, rsp_rdata = 0x00, psel = 0.
